// File: rtl/alu16_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : alu16_pipe_if                                             |
// | Description : Operand/result handshake bundle for the pipelined ALU.    |
// |               master = producer/consumer side, slave = ALU side.        |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
interface alu16_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y;
  logic         N;
  logic         Z;
  logic         C;
  logic         V;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, Y, N, Z, C, V
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, Y, N, Z, C, V
  );
endinterface
`default_nettype wire

// File: rtl/alu16_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : alu16_pipe                                                |
// | Description : Two-stage 16-bit ALU. Stage 1 computes result/C/V,        |
// |               stage 2 adds N/Z and drives the registered outputs.       |
// |               Both stages advance together whenever stage 2 is empty    |
// |               or being drained.                                         |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module alu16_pipe (
  input  wire logic   clk,
  input  wire logic   rst,
  alu16_pipe_if.slave bus
);

  localparam int W = 16;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  // Stage 1 registers
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_y_q,     s1_y_d;
  logic         s1_c_q,     s1_c_d;
  logic         s1_v_q,     s1_v_d;

  // Stage 2 registers (drive the outputs directly)
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] s2_y_q,     s2_y_d;
  logic         s2_n_q,     s2_n_d;
  logic         s2_z_q,     s2_z_d;
  logic         s2_c_q,     s2_c_d;
  logic         s2_v_q,     s2_v_d;

  // Combinational stage-1 datapath
  logic         adv;
  logic [W:0]   sum_w;
  logic [W:0]   diff_w;
  logic [3:0]   shamt;
  logic [4:0]   shl_idx;
  logic [3:0]   shr_idx;
  logic [W-1:0] alu_y;
  logic         alu_c;
  logic         alu_v;

  // A stalled stage 2 freezes the whole pipe, so the input side sees it at once.
  assign adv          = ~s2_valid_q | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = s2_valid_q;
  assign bus.Y         = s2_y_q;
  assign bus.N         = s2_n_q;
  assign bus.Z         = s2_z_q;
  assign bus.C         = s2_c_q;
  assign bus.V         = s2_v_q;

  // Stage-1 operation: result plus carry/shift-out and signed overflow.
  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
    // Subtraction as A + ~B + 1 so the carry reads as "no borrow".
    diff_w  = {1'b0, bus.A} + {1'b0, ~bus.B} + {{W{1'b0}}, 1'b1};
    shamt   = bus.B[3:0];
    // Last bit shifted out: A[W-s] for left, A[s-1] for right (s != 0).
    shl_idx = 5'(W) - {1'b0, shamt};
    shr_idx = shamt - 4'd1;
    case (bus.op)
      OP_ADD: begin
        alu_y = sum_w[W-1:0];
        alu_c = sum_w[W];
        alu_v = (bus.A[W-1] == bus.B[W-1]) && (sum_w[W-1] != bus.A[W-1]);
      end
      OP_SUB: begin
        alu_y = diff_w[W-1:0];
        alu_c = diff_w[W];
        alu_v = (bus.A[W-1] != bus.B[W-1]) && (diff_w[W-1] != bus.A[W-1]);
      end
      OP_AND:   alu_y = bus.A & bus.B;
      OP_OR:    alu_y = bus.A | bus.B;
      OP_XOR:   alu_y = bus.A ^ bus.B;
      OP_SHL: begin
        alu_y = bus.A << shamt;
        if (shamt != 4'd0) alu_c = bus.A[shl_idx[3:0]];
      end
      OP_SHR: begin
        alu_y = bus.A >> shamt;
        if (shamt != 4'd0) alu_c = bus.A[shr_idx];
      end
      OP_PASSB: alu_y = bus.B;
      default:  alu_y = '0;
    endcase
  end

  // Next-state for both stages: shift together on adv, otherwise hold.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_y_d     = s1_y_q;
    s1_c_d     = s1_c_q;
    s1_v_d     = s1_v_q;
    s2_valid_d = s2_valid_q;
    s2_y_d     = s2_y_q;
    s2_n_d     = s2_n_q;
    s2_z_d     = s2_z_q;
    s2_c_d     = s2_c_q;
    s2_v_d     = s2_v_q;
    if (adv) begin
      s1_valid_d = bus.in_valid;
      s1_y_d     = alu_y;
      s1_c_d     = alu_c;
      s1_v_d     = alu_v;
      s2_valid_d = s1_valid_q;
      s2_y_d     = s1_y_q;
      s2_n_d     = s1_y_q[W-1];
      s2_z_d     = (s1_y_q == '0);
      s2_c_d     = s1_c_q;
      s2_v_d     = s1_v_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_y_q     <= '0;
      s1_c_q     <= 1'b0;
      s1_v_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_n_q     <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_c_q     <= 1'b0;
      s2_v_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_y_q     <= s1_y_d;
      s1_c_q     <= s1_c_d;
      s1_v_q     <= s1_v_d;
      s2_valid_q <= s2_valid_d;
      s2_y_q     <= s2_y_d;
      s2_n_q     <= s2_n_d;
      s2_z_q     <= s2_z_d;
      s2_c_q     <= s2_c_d;
      s2_v_q     <= s2_v_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu16_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module      : tb_alu16_pipe                                             |
// | Description : Directed self-checking bench for alu16_pipe.              |
// | Revision    : 1.0  initial release                                      |
// ---------------------------------------------------------------------------
module tb_alu16_pipe;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic [3:0]  nzcv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu16_pipe_if #(.W(16)) bus ();

  alu16_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set for one edge, then a bubble; outputs are then
  // showing that operation's result. early = out_valid after the first edge.
  task automatic apply_op(input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, output logic early);
    bus.op = o; bus.A = a; bus.B = b;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    early = bus.out_valid;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.A = 16'h0001; bus.B = 16'h0001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, bus.out_valid);
      end
      checks++;
      if ({bus.Y, bus.N, bus.Z, bus.C, bus.V} !== 20'h0) begin
        errors++; $display("FAIL reset_outputs[%0d]: Y=%h NZCV=%b%b%b%b want all 0",
                           i, bus.Y, bus.N, bus.Z, bus.C, bus.V);
      end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_ghost_output: got %0d outputs want 0", seen);
    end
  endtask

  task automatic run_table(input string tag, input vec_t v[], input int n);
    logic early;
    for (int i = 0; i < n; i++) begin
      apply_op(v[i].op, v[i].a, v[i].b, early);
      checks++;
      if (early !== 1'b0) begin
        errors++; $display("FAIL %s[%0d] latency: out_valid=%b after 1 edge want 0", tag, i, early);
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL %s[%0d] out_valid: got %b want 1", tag, i, bus.out_valid);
      end
      checks++;
      if (bus.Y !== v[i].y) begin
        errors++; $display("FAIL %s[%0d] Y: got %h want %h", tag, i, bus.Y, v[i].y);
      end
      checks++;
      if ({bus.N, bus.Z, bus.C, bus.V} !== v[i].nzcv) begin
        errors++; $display("FAIL %s[%0d] NZCV: got %b want %b", tag, i,
                           {bus.N, bus.Z, bus.C, bus.V}, v[i].nzcv);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[] = new[3];
    v[0] = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    v[1] = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    v[2] = '{3'b000, 16'h1234, 16'h1111, 16'h2345, 4'b0000};
    run_table("add", v, 3);
  endtask

  task automatic test_sub();
    vec_t v[] = new[3];
    v[0] = '{3'b001, 16'h1234, 16'h1234, 16'h0000, 4'b0110};
    v[1] = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000};
    v[2] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    run_table("sub", v, 3);
  endtask

  task automatic test_shift_logic();
    vec_t v[] = new[10];
    v[0] = '{3'b101, 16'h8001, 16'h0001, 16'h0002, 4'b0010};
    v[1] = '{3'b110, 16'h0003, 16'h0001, 16'h0001, 4'b0010};
    v[2] = '{3'b101, 16'hFFFF, 16'h0000, 16'hFFFF, 4'b1000};
    v[3] = '{3'b100, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
    v[4] = '{3'b010, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    v[5] = '{3'b011, 16'h1200, 16'h0034, 16'h1234, 4'b0000};
    v[6] = '{3'b111, 16'h5555, 16'h8000, 16'h8000, 4'b1000};
    v[7] = '{3'b110, 16'h8000, 16'h000F, 16'h0001, 4'b0000};
    v[8] = '{3'b101, 16'h0001, 16'h000F, 16'h8000, 4'b1000};
    v[9] = '{3'b101, 16'h4000, 16'h0002, 16'h0000, 4'b0110};
    run_table("shlog", v, 10);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ea[4];
    logic [15:0] eb[4];
    logic [15:0] ey[4];
    logic [3:0]  ef[4];
    logic [15:0] held_y;
    logic [3:0]  held_f;
    logic        stalled;
    int          sent, recv, stall_cycles;
    ea = '{16'h0001, 16'h0010, 16'h7FFF, 16'hFFFF};
    eb = '{16'h0001, 16'h0020, 16'h0001, 16'h0002};
    ey = '{16'h0002, 16'h0030, 16'h8000, 16'h0001};
    ef = '{4'b0000,  4'b0000,  4'b1001,  4'b0010};
    sent = 0; recv = 0; stall_cycles = 0; stalled = 1'b0;
    held_y = '0; held_f = '0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); tick(); tick();
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      bus.in_valid  = (sent < 4);
      bus.op = 3'b000;
      if (sent < 4) begin
        bus.A = ea[sent]; bus.B = eb[sent];
      end
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        stall_cycles++;
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_in_ready cyc%0d: got %b want 0", cyc, bus.in_ready);
        end
        if (stalled) begin
          checks++;
          if (bus.Y !== held_y || {bus.N, bus.Z, bus.C, bus.V} !== held_f) begin
            errors++; $display("FAIL b2b_hold cyc%0d: Y=%h NZCV=%b want Y=%h NZCV=%b",
                               cyc, bus.Y, {bus.N, bus.Z, bus.C, bus.V}, held_y, held_f);
          end
        end
        held_y = bus.Y; held_f = {bus.N, bus.Z, bus.C, bus.V};
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (recv >= 4) begin
          errors++; $display("FAIL b2b_extra: result %0d Y=%h want none", recv, bus.Y);
        end else if (bus.Y !== ey[recv] || {bus.N, bus.Z, bus.C, bus.V} !== ef[recv]) begin
          errors++; $display("FAIL b2b_result[%0d]: Y=%h NZCV=%b want Y=%h NZCV=%b", recv,
                             bus.Y, {bus.N, bus.Z, bus.C, bus.V}, ey[recv], ef[recv]);
        end
        recv++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (recv !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d results want 4", recv);
    end
    checks++;
    if (stall_cycles !== 3) begin
      errors++; $display("FAIL b2b_stall_cycles: got %0d want 3", stall_cycles);
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.A = 16'h0001; bus.B = 16'h0002;
    tick();
    bus.op = 3'b001; bus.A = 16'h0005; bus.B = 16'h0003;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Y !== 16'h0000) begin
      errors++; $display("FAIL midrst_flush: out_valid=%b Y=%h want 0 0000", bus.out_valid, bus.Y);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL midrst_ghost: got %0d outputs want 0", seen);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.A = '0; bus.B = '0; bus.op = '0;
    test_reset();
    test_arith();
    test_sub();
    test_shift_logic();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu16_pipe.md
# alu16_pipe

Two-stage pipelined 16-bit ALU that produces a result word and the N/Z/C/V status flags with a valid/ready handshake on both sides. It sits directly upstream of the zero-flag detector in the Laboratorio 3 datapath. Its registered result is the operand that detector evaluates, and this block also exports its own registered Z so the flag register and branch logic need no extra combinational stage. Stage 1 performs the arithmetic/logic operation; stage 2 derives the flags and presents the output.

## Interface
- W, 16, operand/result width; the shift amount is always B[3:0].
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set A/B/op is valid.
- in_ready  out  1  block accepts the operand set this cycle.
- A  in  W  operand A.
- B  in  W  operand B.
- op  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 PASSB.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result this cycle.
- Y  out  W  result.
- N  out  1  Y[W-1].
- Z  out  1  1 when Y == 0.
- C  out  1  carry / shift-out.
- V  out  1  signed overflow.

## Operation
- Transfers:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Pipeline stages:
  - Stage 1 register holds s1_valid, the W-bit result, C and V.
  - Stage 2 register holds s2_valid, Y, C, V, plus N and Z computed from the stage-1 result.
- Advance rule:
  - adv = ~s2_valid | out_ready, and in_ready = adv.
  - When adv = 1, both stages shift: stage 2 <- stage 1, stage 1 <- input, and s1_valid <- in_valid.
  - When adv = 0, both stages hold all contents unchanged.
- Bubbles propagate: an invalid stage-1 slot moves into stage 2 as s2_valid = 0.
- Arithmetic and flag rules (all results truncated to W bits):
  - ADD: C = carry out of A+B. V = (A[W-1]==B[W-1]) & (sum[W-1]!=A[W-1]).
  - SUB: computed as A + ~B + 1. C = carry out, so C=1 means A >= B unsigned. V = (A[W-1]!=B[W-1]) & (diff[W-1]!=A[W-1]).
  - AND/OR/XOR/PASSB: C = 0, V = 0.
  - SHL by s=B[3:0]: C = A[W-s] when s != 0, else 0. V = 0. Zeros shift in.
  - SHR by s: C = A[s-1] when s != 0, else 0. V = 0. Zeros shift in.
  - N = Y[W-1] and Z = (Y == 0) for every op.
- Outputs Y/N/Z/C/V come directly from stage-2 registers. While out_valid = 0 they hold their last values, and consumers ignore them.

## Timing
- Reset (rst = 1 at a rising edge):
  - s1_valid = 0, s2_valid = 0.
  - Y = 0, N = 0, Z = 0, C = 0, V = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-operation: any in-flight stage-1 or stage-2 data is discarded with no output transfer. rst overrides adv.
- Latency: an operand accepted at edge k appears with out_valid = 1 after edge k+1, i.e. 2 cycles.
- Throughput: 1 result per cycle while out_ready = 1.
- Backpressure:
  - With out_valid = 1 and out_ready = 0, in_ready = 0 combinationally in the same cycle.
  - Y and the flags stay stable until the output transfer.
- Pipeline full, consumer stalled: no data is lost or duplicated. The stage-1 item enters stage 2 on the edge where out_ready = 1.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both legal and required for full throughput.
- in_valid = 0 while adv = 1 inserts a bubble.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1 throughout -> out_valid = 0, Y = 0, all flags 0, in_ready = 1 after release, and no output ever appears for the inputs presented during reset.
- Arithmetic flags:
  - ADD 0x7FFF + 0x0001 -> Y = 0x8000, N = 1, Z = 0, C = 0, V = 1, two cycles after acceptance.
  - ADD 0xFFFF + 0x0001 -> Y = 0x0000, Z = 1, C = 1, V = 0.
- SUB and zero: SUB 0x1234 - 0x1234 -> Y = 0, Z = 1, C = 1, V = 0. SUB 0x0000 - 0x0001 -> Y = 0xFFFF, N = 1, C = 0.
- Shifts and logic:
  - SHL 0x8001 by 1 -> Y = 0x0002, C = 1.
  - SHR 0x0003 by 1 -> Y = 0x0001, C = 1.
  - SHL by 0 -> C = 0.
  - XOR 0xAAAA ^ 0xAAAA -> Z = 1, C = 0, V = 0.
- Backpressure:
  - Stream 4 ADDs back-to-back with out_ready held 0 from cycle 2 for 3 cycles -> in_ready drops, Y/flags held stable.
  - All 4 results are delivered in order, exactly once, after out_ready returns to 1.
- Mid-stream reset: accept 2 ops, assert rst for 1 cycle before the first output -> out_valid = 0, and neither result is ever delivered.
